decode_stage: RTL
=================

Name: decode_stage

Overview:
- Buffered, handshaked RV32I decode stage that replaces the purely combinational decoder between fetch and execute.
- Accepts instruction/PC pairs from fetch into a DEPTH-entry FIFO and decodes the FIFO head.
- Registers the decoded control bundle into an output stage with valid/ready back-pressure.
- Adds synchronous flush (branch redirect), illegal-instruction detection, occupancy reporting and a parametrised PC width.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2 to 16.
- PC_W, 32, width of carried PC.
- CW, $clog2(DEPTH+1), width of o_count; derived, not overridden.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_flush  input  1  synchronous flush; discards all buffered and output-stage instructions
- i_valid  input  1  fetch offers i_inst/i_pc
- o_ready  output  1  stage can accept; equals FIFO not full
- i_inst  input  32  instruction word
- i_pc  input  PC_W  instruction address
- o_valid  output  1  decoded bundle valid
- i_ready  input  1  execute accepts bundle
- o_pc  output  PC_W  PC of the decoded instruction
- o_rs1, o_rs2, o_rd  output  5 each  register fields (inst[19:15], [24:20], [11:7])
- o_regWrite  output  1  write rd; forced 0 when rd==0
- o_ALUCtrl  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- o_ALUSrcA  output  1  0 rs1, 1 PC (AUIPC, JAL, JALR link)
- o_ALUSrc  output  1  0 rs2, 1 imm
- o_resultSrc  output  2  0 ALU, 1 memory, 2 PC+4
- o_PCSrc  output  2  0 PC+4, 1 conditional branch, 2 JAL, 3 JALR
- o_memRead, o_memWrite  output  1 each  load/store
- o_funct3  output  3  passed through for branch/load/store width
- o_imm  output  32  sign-extended I/S/B/U/J immediate by opcode; 0 for R-type/FENCE/SYSTEM
- o_illegal  output  1  unsupported encoding
- o_count  output  CW  FIFO occupancy (excludes output stage)

Behaviour:
- Reset (i_rst_n low, asynchronous): FIFO empty, o_count=0, o_ready=1, o_valid=0, all bundle outputs 0.
- Push: i_valid && o_ready at an edge writes the tail entry. o_ready is a combinational function of the registered count only, never of i_ready.
- Output-stage load: when FIFO non-empty and (!o_valid || i_ready), the head is decoded combinationally, registered into the bundle, popped, and o_valid=1.
- Output-stage drain: when FIFO empty and i_ready is high, o_valid goes to 0 at the next edge.
- Hold: while o_valid && !i_ready, all outputs hold stable.
- Latency: push at edge N gives o_valid at edge N+1 when the output stage is free; there is no same-cycle bypass.
- Throughput: one instruction per cycle sustained.
- Simultaneous push and pop at full: no push is possible because o_ready=0 at full.
- Simultaneous push and pop otherwise: count is unchanged; pointers wrap modulo DEPTH.
- Flush (i_flush=1 at an edge): count=0, pointers=0, o_valid=0, and the same-cycle push is discarded. Flush has priority over push and load.
- Decode by opcode [6:0]:
  - 0110111 LUI: PASSB, imm U, ALUSrc=1.
  - 0010111 AUIPC: ADD, A=PC, imm U.
  - 1101111 JAL: PCSrc=2, result=2.
  - 1100111 JALR: requires funct3=0; PCSrc=3, result=2, imm I.
  - 1100011 BRANCH: SUB, PCSrc=1, funct3 010/011 illegal.
  - 0000011 LOAD: funct3 in {0,1,2,4,5}, memRead, result=1.
  - 0100011 STORE: funct3 in {0,1,2}, memWrite, no regWrite.
  - 0010011 OP-IMM: funct3 001 requires funct7=0; funct3 101 requires funct7 0000000 (SRL) or 0100000 (SRA).
  - 0110011 OP: funct7 0100000 is allowed only with funct3 000 (SUB) or 101 (SRA); any other funct7 besides 0000000 is illegal.
  - 0001111 FENCE and 1110011 SYSTEM: decode as no-op (regWrite=0, no memory access), not illegal.
- Illegal instructions: o_illegal=1, and regWrite, memRead, memWrite and PCSrc are forced 0. PC and raw fields still pass through.

Test Plan:
- Reset mid-stream with 3 entries buffered: drop i_rst_n -> o_valid=0, o_count=0 and o_ready=1 immediately; no edge is needed.
- Push 0x00500093 (addi x1,x0,5) at PC 0x100 with i_ready=1 -> next cycle o_valid=1, rd=1, ALUCtrl=0, ALUSrc=1, imm=5, regWrite=1, o_pc=0x100.
- Hold i_ready=0 and push 5 instructions with DEPTH=4 -> o_ready drops after 4 FIFO entries plus 1 in the output stage, o_count=4. Release i_ready -> 5 bundles emerge in order on consecutive cycles, with wrap-around correct.
- i_flush while full and with i_valid=1 -> next cycle o_valid=0, o_count=0, and the flush-cycle instruction never appears.
- Push 0xFE000EE3 (beq x0,x0,-4) -> PCSrc=1, ALUCtrl=1, imm=0xFFFFFFFC, regWrite=0.
- Push 0x4000D0B3 (illegal funct7 on OR/SRL variant check: sra) -> ALUCtrl=7, not illegal. Push 0x40001033 -> o_illegal=1 with all enables 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/execute handshake bundle for the RV32I decode stage
//
// Purpose : groups every non-clock, non-reset signal of decode_stage.
// Ports   : fetch side  i_flush, i_valid, o_ready, i_inst, i_pc
//           execute side o_valid, i_ready and the decoded control bundle
//           status       o_count (FIFO occupancy, output stage excluded)
// Modports: master = environment (fetch/execute), slave = decode_stage.
interface decode_stage_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_inst;
    logic [PC_W-1:0] i_pc;

    logic            o_valid;
    logic            i_ready;
    logic [PC_W-1:0] o_pc;
    logic [4:0]      o_rs1;
    logic [4:0]      o_rs2;
    logic [4:0]      o_rd;
    logic            o_regWrite;
    logic [3:0]      o_ALUCtrl;
    logic            o_ALUSrcA;
    logic            o_ALUSrc;
    logic [1:0]      o_resultSrc;
    logic [1:0]      o_PCSrc;
    logic            o_memRead;
    logic            o_memWrite;
    logic [2:0]      o_funct3;
    logic [31:0]     o_imm;
    logic            o_illegal;
    logic [CW-1:0]   o_count;

    modport master (
        output i_flush, i_valid, i_inst, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_regWrite, o_ALUCtrl,
               o_ALUSrcA, o_ALUSrc, o_resultSrc, o_PCSrc, o_memRead, o_memWrite,
               o_funct3, o_imm, o_illegal, o_count
    );

    modport slave (
        input  i_flush, i_valid, i_inst, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_rs1, o_rs2, o_rd, o_regWrite, o_ALUCtrl,
               o_ALUSrcA, o_ALUSrc, o_resultSrc, o_PCSrc, o_memRead, o_memWrite,
               o_funct3, o_imm, o_illegal, o_count
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - buffered, handshaked RV32I decode stage
//
// Purpose : DEPTH-entry instruction/PC FIFO whose head is decoded and
//           registered into a valid/ready output stage.
// Ports   : i_clk, i_rst_n (async active-low)
//           bus (decode_stage_if.slave): fetch push, execute pop, flush,
//           decoded control bundle and occupancy.
module decode_stage #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    decode_stage_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic [3:0]      alu_ctrl;
        logic            alu_src_a;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [1:0]      pc_src;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        logic            illegal;
    } bundle_t;

    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     inst_mem_d [DEPTH];
    logic [PC_W-1:0] pc_mem_q   [DEPTH];
    logic [PC_W-1:0] pc_mem_d   [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    bundle_t         bndl_q, bndl_d, dec;

    logic            full, push, load;
    logic [31:0]     head_inst;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;

    // Ready depends only on registered occupancy, so there is no comb path
    // from execute's i_ready back to fetch.
    assign full = (count_q == CW'(DEPTH));
    assign push = bus.i_valid && !full;
    assign load = (count_q != '0) && (!out_valid_q || bus.i_ready);

    assign head_inst = inst_mem_q[rd_ptr_q];
    assign opcode    = head_inst[6:0];
    assign funct3    = head_inst[14:12];
    assign funct7    = head_inst[31:25];
    assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                    head_inst[11:8], 1'b0};
    assign imm_u = {head_inst[31:12], 12'b0};
    assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                    head_inst[30:21], 1'b0};

    // funct3 -> ALU op shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec        = '0;
        dec.pc     = pc_mem_q[rd_ptr_q];
        dec.rs1    = head_inst[19:15];
        dec.rs2    = head_inst[24:20];
        dec.rd     = head_inst[11:7];
        dec.funct3 = funct3;
        case (opcode)
            7'b0110111: begin
                dec.alu_ctrl = ALU_PASSB; dec.alu_src = 1'b1; dec.imm = imm_u; dec.reg_write = 1'b1;
            end
            7'b0010111: begin
                dec.alu_src_a = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_u; dec.reg_write = 1'b1;
            end
            7'b1101111: begin
                dec.alu_src_a = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_j; dec.reg_write = 1'b1;
                dec.pc_src = 2'd2; dec.result_src = 2'd2;
            end
            7'b1100111: begin
                dec.alu_src_a = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_i; dec.reg_write = 1'b1;
                dec.pc_src = 2'd3; dec.result_src = 2'd2;
                dec.illegal = (funct3 != 3'b000);
            end
            7'b1100011: begin
                dec.alu_ctrl = ALU_SUB; dec.imm = imm_b; dec.pc_src = 2'd1;
                dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b0000011: begin
                dec.alu_src = 1'b1; dec.imm = imm_i; dec.reg_write = 1'b1;
                dec.mem_read = 1'b1; dec.result_src = 2'd1;
                dec.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            7'b0100011: begin
                dec.alu_src = 1'b1; dec.imm = imm_s; dec.mem_write = 1'b1;
                dec.illegal = (funct3 > 3'b010);
            end
            7'b0010011: begin
                dec.alu_src = 1'b1; dec.imm = imm_i; dec.reg_write = 1'b1;
                dec.alu_ctrl = alu_of(funct3, 1'b0);
                if (funct3 == 3'b001) begin
                    dec.illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec.alu_ctrl = alu_of(funct3, funct7[5]);
                    dec.illegal  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            7'b0110011: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_of(funct3, funct7[5]);
                if (funct7 == 7'b0100000) begin
                    dec.illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else begin
                    dec.illegal = (funct7 != 7'b0000000);
                end
            end
            7'b0001111, 7'b1110011: ;   // FENCE/SYSTEM retire as no-ops
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.pc_src    = 2'd0;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    always_comb begin
        inst_mem_d  = inst_mem_q;
        pc_mem_d    = pc_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        bndl_d      = bndl_q;
        if (bus.i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = bus.i_inst;
                pc_mem_d[wr_ptr_q]   = bus.i_pc;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (load) begin
                bndl_d      = dec;
                rd_ptr_d    = rd_ptr_q + AW'(1);
                out_valid_d = 1'b1;
            end else if (bus.i_ready) begin
                out_valid_d = 1'b0;   // consumed with nothing behind it
            end
            count_d = count_q + CW'(push) - CW'(load);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            bndl_q      <= '0;
        end else begin
            inst_mem_q  <= inst_mem_d;
            pc_mem_q    <= pc_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            bndl_q      <= bndl_d;
        end
    end

    assign bus.o_ready     = !full;
    assign bus.o_count     = count_q;
    assign bus.o_valid     = out_valid_q;
    assign bus.o_pc        = bndl_q.pc;
    assign bus.o_rs1       = bndl_q.rs1;
    assign bus.o_rs2       = bndl_q.rs2;
    assign bus.o_rd        = bndl_q.rd;
    assign bus.o_regWrite  = bndl_q.reg_write;
    assign bus.o_ALUCtrl   = bndl_q.alu_ctrl;
    assign bus.o_ALUSrcA   = bndl_q.alu_src_a;
    assign bus.o_ALUSrc    = bndl_q.alu_src;
    assign bus.o_resultSrc = bndl_q.result_src;
    assign bus.o_PCSrc     = bndl_q.pc_src;
    assign bus.o_memRead   = bndl_q.mem_read;
    assign bus.o_memWrite  = bndl_q.mem_write;
    assign bus.o_funct3    = bndl_q.funct3;
    assign bus.o_imm       = bndl_q.imm;
    assign bus.o_illegal   = bndl_q.illegal;
endmodule
